// File: rtl/oflow_dma_set_packer.sv
// oflow_dma_set_packer
// Packs a per-frame stream of bbox words into sets of PE_NUM slots and hands
// each completed set to the core once the core has granted the matching credit
// (a frame credit for the first set of a frame, a set credit for the others).
module oflow_dma_set_packer #(
  parameter int PE_NUM           = 24,
  parameter int BBOX_VECTOR_SIZE = 86,
  parameter int FRAME_CNT_WIDTH  = 7
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_start,
  input  logic [FRAME_CNT_WIDTH-1:0]         frame_bbox_count,
  input  logic [BBOX_VECTOR_SIZE-1:0]        bbox_in,
  input  logic                               bbox_valid,
  output logic                               bbox_ready,
  input  logic                               ready_new_frame,
  input  logic                               ready_new_set,
  output logic [PE_NUM*BBOX_VECTOR_SIZE-1:0] set_of_bboxes_from_dma,
  output logic [4:0]                         set_valid_cnt,
  output logic                               new_frame,
  output logic                               new_set_from_dma,
  output logic                               frame_sent,
  output logic                               busy
);

  // The slot index must also hold the "all slots written" value PE_NUM while
  // a full set waits for its credit, hence PE_NUM+1 codes.
  localparam int SLOT_W = $clog2(PE_NUM + 1);
  localparam int SET_W  = PE_NUM * BBOX_VECTOR_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                      state_q, state_d;

  // Frame bookkeeping
  logic [FRAME_CNT_WIDTH-1:0]  count_q;
  logic [FRAME_CNT_WIDTH-1:0]  bbox_cnt_q;
  logic [FRAME_CNT_WIDTH-1:0]  bbox_cnt_inc;
  logic [SLOT_W-1:0]           slot_q;
  logic                        first_set_sent_q;

  // Fill buffer: slots not written in the current set stay zero
  logic [BBOX_VECTOR_SIZE-1:0] fill_q [PE_NUM];

  // Registered outputs
  logic [SET_W-1:0]            out_set_q;
  logic [4:0]                  out_cnt_q;
  logic                        new_frame_q;
  logic                        new_set_q;
  logic                        frame_sent_q;

  // Credit tracking
  logic                        rnf_q, rns_q;
  logic                        frame_credit_q, frame_credit_d;
  logic                        set_credit_q, set_credit_d;
  logic                        frame_edge, set_edge;
  logic                        frame_consume, set_consume;

  // Qualifiers
  logic                        start_ok;
  logic                        hs;
  logic                        slot_last;
  logic                        cnt_last;
  logic                        set_done;
  logic                        credit_ok;
  logic                        issue;
  logic                        more_left;

  // Datapath qualifiers shared by the FSM and the register blocks
  always_comb begin
    bbox_cnt_inc = bbox_cnt_q + FRAME_CNT_WIDTH'(1);
    start_ok     = (state_q == S_IDLE) && frame_start &&
                   (frame_bbox_count != '0);
    hs           = (state_q == S_FILL) && bbox_valid;
    slot_last    = (slot_q == SLOT_W'(PE_NUM - 1));
    cnt_last     = (bbox_cnt_inc == count_q);
    set_done     = hs && (slot_last || cnt_last);
    credit_ok    = first_set_sent_q ? set_credit_q : frame_credit_q;
    issue        = (state_q == S_WAIT) && credit_ok;
    more_left    = (bbox_cnt_q != count_q);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_FILL;
      end
      S_FILL: begin
        if (set_done) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (issue) state_d = more_left ? S_FILL : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: input side is open only while filling
  always_comb begin
    bbox_ready = (state_q == S_FILL);
    busy       = (state_q != S_IDLE);
  end

  // Fill buffer, slot index and frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PE_NUM; i++) fill_q[i] <= '0;
      slot_q           <= '0;
      bbox_cnt_q       <= '0;
      count_q          <= '0;
      first_set_sent_q <= 1'b0;
    end else if (start_ok) begin
      for (int i = 0; i < PE_NUM; i++) fill_q[i] <= '0;
      slot_q           <= '0;
      bbox_cnt_q       <= '0;
      count_q          <= frame_bbox_count;
      first_set_sent_q <= 1'b0;
    end else if (hs) begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (slot_q == SLOT_W'(i)) fill_q[i] <= bbox_in;
      end
      slot_q     <= slot_q + SLOT_W'(1);
      bbox_cnt_q <= bbox_cnt_inc;
    end else if (issue) begin
      for (int i = 0; i < PE_NUM; i++) fill_q[i] <= '0;
      slot_q           <= '0;
      first_set_sent_q <= 1'b1;
    end
  end

  // Presented set and its one-cycle pulses; data holds between issues
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_set_q    <= '0;
      out_cnt_q    <= '0;
      new_frame_q  <= 1'b0;
      new_set_q    <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      new_frame_q  <= 1'b0;
      new_set_q    <= 1'b0;
      frame_sent_q <= 1'b0;
      if (issue) begin
        for (int i = 0; i < PE_NUM; i++) begin
          out_set_q[i*BBOX_VECTOR_SIZE +: BBOX_VECTOR_SIZE] <= fill_q[i];
        end
        out_cnt_q    <= 5'(slot_q);
        new_frame_q  <= ~first_set_sent_q;
        new_set_q    <= first_set_sent_q;
        frame_sent_q <= ~more_left;
      end
    end
  end

  // Credit next-state: a fresh grant wins over a same-cycle consume
  always_comb begin
    frame_edge     = ready_new_frame & ~rnf_q;
    set_edge       = ready_new_set & ~rns_q;
    frame_consume  = issue & ~first_set_sent_q;
    set_consume    = issue & first_set_sent_q;
    frame_credit_d = frame_edge | (frame_credit_q & ~frame_consume);
    set_credit_d   = set_edge | (set_credit_q & ~set_consume);
  end

  // Credit registers; the core is idle after reset so one frame credit exists
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnf_q          <= 1'b0;
      rns_q          <= 1'b0;
      frame_credit_q <= 1'b1;
      set_credit_q   <= 1'b0;
    end else begin
      rnf_q          <= ready_new_frame;
      rns_q          <= ready_new_set;
      frame_credit_q <= frame_credit_d;
      set_credit_q   <= set_credit_d;
    end
  end

  assign set_of_bboxes_from_dma = out_set_q;
  assign set_valid_cnt          = out_cnt_q;
  assign new_frame              = new_frame_q;
  assign new_set_from_dma       = new_set_q;
  assign frame_sent             = frame_sent_q;

endmodule

// File: tb/tb_oflow_dma_set_packer.sv
// Bench for oflow_dma_set_packer: random bbox data and handshakes, sets
// predicted from the accepted-bbox list (set k = accepted bboxes 24k..24k+23).
module tb_oflow_dma_set_packer;

  localparam int PE   = 24;
  localparam int BVS  = 86;
  localparam int FCW  = 7;
  localparam int SETW = PE * BVS;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic [FCW-1:0]  frame_bbox_count;
  logic [BVS-1:0]  bbox_in;
  logic            bbox_valid;
  logic            bbox_ready;
  logic            ready_new_frame;
  logic            ready_new_set;
  logic [SETW-1:0] set_of_bboxes_from_dma;
  logic [4:0]      set_valid_cnt;
  logic            new_frame;
  logic            new_set_from_dma;
  logic            frame_sent;
  logic            busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [SETW-1:0] data;
    logic [4:0]      cnt;
    logic            nf, ns, fs, rdy;
    int              cyc;
  } set_obs_t;

  logic [BVS-1:0] acc_q[$];
  int             acc_cyc_q[$];
  set_obs_t       sets_q[$];
  set_obs_t       mon_o;

  oflow_dma_set_packer #(
    .PE_NUM(PE), .BBOX_VECTOR_SIZE(BVS), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .frame_bbox_count(frame_bbox_count), .bbox_in(bbox_in),
    .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
    .ready_new_frame(ready_new_frame), .ready_new_set(ready_new_set),
    .set_of_bboxes_from_dma(set_of_bboxes_from_dma),
    .set_valid_cnt(set_valid_cnt), .new_frame(new_frame),
    .new_set_from_dma(new_set_from_dma), .frame_sent(frame_sent),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation: accepted bboxes and every presented set, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (bbox_valid && bbox_ready) begin
        acc_q.push_back(bbox_in);
        acc_cyc_q.push_back(cyc);
      end
      if (new_frame || new_set_from_dma || frame_sent) begin
        mon_o.data = set_of_bboxes_from_dma;
        mon_o.cnt  = set_valid_cnt;
        mon_o.nf   = new_frame;
        mon_o.ns   = new_set_from_dma;
        mon_o.fs   = frame_sent;
        mon_o.rdy  = bbox_ready;
        mon_o.cyc  = cyc;
        sets_q.push_back(mon_o);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [SETW-1:0] exp_set(int k, int total);
    logic [SETW-1:0] v;
    v = '0;
    for (int i = 0; i < PE; i++) begin
      if ((k * PE + i) < total && (k * PE + i) < acc_q.size())
        v[i*BVS +: BVS] = acc_q[k*PE + i];
    end
    return v;
  endfunction

  // {cnt[4:0], new_frame, new_set, frame_sent}
  function automatic logic [7:0] exp_meta(int k, int total);
    int rem;
    logic [4:0] c;
    rem = total - k * PE;
    c = 5'((rem > PE) ? PE : rem);
    return {c, 1'(k == 0), 1'(k != 0), 1'(rem <= PE)};
  endfunction

  function automatic int first_diff(logic [SETW-1:0] a, logic [SETW-1:0] b);
    for (int i = 0; i < PE; i++)
      if (a[i*BVS +: BVS] !== b[i*BVS +: BVS]) return i;
    return 0;
  endfunction

  function automatic logic [BVS-1:0] rand_bbox();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[BVS-1:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc_q.delete();
    acc_cyc_q.delete();
    sets_q.delete();
  endtask

  task automatic pulse_frame_credit();
    tick(); ready_new_frame = 1'b1;
    tick(); ready_new_frame = 1'b0;
  endtask

  task automatic pulse_set_credit();
    tick(); ready_new_set = 1'b1;
    tick(); ready_new_set = 1'b0;
  endtask

  task automatic start_frame(input logic [FCW-1:0] c);
    tick(); frame_start = 1'b1; frame_bbox_count = c;
    tick(); frame_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bbox_ready, new_frame, new_set_from_dma, frame_sent} !== 5'b0) begin
      fails++;
      $display("FAIL rst_ctrl got=%b exp=00000",
               {busy, bbox_ready, new_frame, new_set_from_dma, frame_sent});
    end
    tick(); reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (set_of_bboxes_from_dma !== '0 || set_valid_cnt !== 5'd0) begin
      fails++;
      $display("FAIL rst_out got cnt=%0d set_nonzero=%0b exp cnt=0 set_nonzero=0",
               set_valid_cnt, set_of_bboxes_from_dma != '0);
    end
    checks++;
    if ({busy, bbox_ready} !== 2'b00) begin
      fails++;
      $display("FAIL rst_idle got busy/ready=%b exp=00", {busy, bbox_ready});
    end
  endtask

  task automatic test_frame72();
    int seen, budget, idx;
    clear_obs();
    pulse_frame_credit();
    start_frame(7'd72);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    seen = 0; budget = 0;
    while (sets_q.size() < 3 && budget < 400) begin
      tick();
      bbox_in = rand_bbox();
      ready_new_set = (sets_q.size() != seen);
      seen = sets_q.size();
      budget++;
    end
    bbox_valid = 1'b0; ready_new_set = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 3 || acc_q.size() !== 72) begin
      fails++;
      $display("FAIL f72_count got sets=%0d acc=%0d exp sets=3 acc=72", sets_q.size(), acc_q.size());
    end
    for (int k = 0; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 72); em = exp_meta(k, 72);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL f72_data set=%0d slot=%0d got=%h exp=%h", k, d, sets_q[k].data[d*BVS +: BVS], ev[d*BVS +: BVS]);
      end
      checks++;
      if (gm !== em) begin
        fails++;
        $display("FAIL f72_meta set=%0d got cnt/nf/ns/fs=%h exp=%h", k, gm, em);
      end
      idx = ((k + 1) * PE > 72 ? 72 : (k + 1) * PE) - 1;
      if (idx < acc_cyc_q.size()) begin
        checks++;
        if ((sets_q[k].cyc - acc_cyc_q[idx]) !== 2 || sets_q[k].rdy !== (k < 2)) begin
          fails++;
          $display("FAIL f72_latency set=%0d got lat=%0d rdy=%0b exp lat=2 rdy=%0b",
                   k, sets_q[k].cyc - acc_cyc_q[idx], sets_q[k].rdy, k < 2);
        end
      end
    end
  endtask

  task automatic test_frame30();
    int budget;
    clear_obs();
    pulse_frame_credit();
    pulse_set_credit();
    start_frame(7'd30);
    budget = 0;
    while (sets_q.size() < 2 && budget < 600) begin
      tick();
      bbox_in = rand_bbox();
      bbox_valid = 1'($urandom_range(0, 1));
      budget++;
    end
    bbox_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 2 || acc_q.size() !== 30) begin
      fails++;
      $display("FAIL f30_count got sets=%0d acc=%0d exp sets=2 acc=30", sets_q.size(), acc_q.size());
    end
    for (int k = 0; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 30); em = exp_meta(k, 30);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL f30_data set=%0d slot=%0d got=%h exp=%h", k, d, sets_q[k].data[d*BVS +: BVS], ev[d*BVS +: BVS]);
      end
      checks++;
      if (gm !== em) begin
        fails++;
        $display("FAIL f30_meta set=%0d got cnt/nf/ns/fs=%h exp=%h", k, gm, em);
      end
    end
  endtask

  task automatic test_stall();
    int seen, budget;
    clear_obs();
    pulse_frame_credit();
    start_frame(7'd72);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    repeat (90) begin
      tick();
      bbox_in = rand_bbox();
    end
    @(negedge clk);
    checks++;
    if (acc_q.size() !== 48 || {busy, bbox_ready} !== 2'b10 || sets_q.size() !== 1) begin
      fails++;
      $display("FAIL stall_hold got acc=%0d busy/ready=%b sets=%0d exp acc=48 busy/ready=10 sets=1",
               acc_q.size(), {busy, bbox_ready}, sets_q.size());
    end
    checks++;
    if (set_of_bboxes_from_dma !== exp_set(0, 72) || set_valid_cnt !== 5'd24) begin
      fails++;
      $display("FAIL stall_out got cnt=%0d set0_match=%0b exp cnt=24 set0_match=1",
               set_valid_cnt, set_of_bboxes_from_dma === exp_set(0, 72));
    end
    tick(); ready_new_set = 1'b1;
    seen = 1; budget = 0;
    while (sets_q.size() < 3 && budget < 300) begin
      tick();
      bbox_in = rand_bbox();
      ready_new_set = (sets_q.size() != seen);
      seen = sets_q.size();
      budget++;
    end
    bbox_valid = 1'b0; ready_new_set = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 3 || acc_q.size() !== 72) begin
      fails++;
      $display("FAIL stall_resume got sets=%0d acc=%0d exp sets=3 acc=72", sets_q.size(), acc_q.size());
    end
    for (int k = 0; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 72); em = exp_meta(k, 72);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL stall_data set=%0d slot=%0d got=%h exp=%h", k, d, sets_q[k].data[d*BVS +: BVS], ev[d*BVS +: BVS]);
      end
      checks++;
      if (gm !== em) begin
        fails++;
        $display("FAIL stall_meta set=%0d got cnt/nf/ns/fs=%h exp=%h", k, gm, em);
      end
    end
  endtask

  task automatic test_ignore_start();
    int budget;
    clear_obs();
    pulse_frame_credit();
    pulse_set_credit();
    start_frame(7'd30);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    repeat (5) begin
      tick();
      bbox_in = rand_bbox();
    end
    tick(); bbox_valid = 1'b0; frame_start = 1'b1; frame_bbox_count = 7'd5;
    tick(); frame_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, bbox_ready} !== 2'b11) begin
      fails++;
      $display("FAIL ign_fill got busy/ready=%b exp=11", {busy, bbox_ready});
    end
    budget = 0;
    while (sets_q.size() < 2 && budget < 400) begin
      tick();
      bbox_in = rand_bbox();
      bbox_valid = 1'($urandom_range(0, 1));
      budget++;
    end
    bbox_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 2 || acc_q.size() !== 30) begin
      fails++;
      $display("FAIL ign_count got sets=%0d acc=%0d exp sets=2 acc=30", sets_q.size(), acc_q.size());
    end
    for (int k = 0; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 30); em = exp_meta(k, 30);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL ign_data set=%0d slot=%0d got=%h exp=%h", k, d, sets_q[k].data[d*BVS +: BVS], ev[d*BVS +: BVS]);
      end
      checks++;
      if (gm !== em) begin
        fails++;
        $display("FAIL ign_meta set=%0d got cnt/nf/ns/fs=%h exp=%h", k, gm, em);
      end
    end
    start_frame(7'd0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, bbox_ready} !== 2'b00 || sets_q.size() !== 2) begin
      fails++;
      $display("FAIL ign_zero got busy/ready=%b sets=%0d exp busy/ready=00 sets=2",
               {busy, bbox_ready}, sets_q.size());
    end
  endtask

  task automatic test_simul_edge();
    int budget, fired;
    clear_obs();
    pulse_frame_credit();
    pulse_set_credit();
    start_frame(7'd72);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    budget = 0; fired = 0;
    while (sets_q.size() < 3 && budget < 400) begin
      tick();
      bbox_in = rand_bbox();
      ready_new_set = 1'b0;
      // first cycle after the 48th accept is the set-1 issue cycle
      if (fired == 0 && acc_q.size() == 48) begin
        ready_new_set = 1'b1;
        fired = 1;
      end
      budget++;
    end
    bbox_valid = 1'b0; ready_new_set = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 3 || acc_q.size() !== 72) begin
      fails++;
      $display("FAIL simul_count got sets=%0d acc=%0d exp sets=3 acc=72", sets_q.size(), acc_q.size());
    end
    for (int k = 1; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 72); em = exp_meta(k, 72);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev || gm !== em) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL simul_set set=%0d got meta=%h slot%0d=%h exp meta=%h slot=%h",
                 k, gm, d, sets_q[k].data[d*BVS +: BVS], em, ev[d*BVS +: BVS]);
      end
      if (k * PE + PE - 1 < acc_cyc_q.size()) begin
        checks++;
        if ((sets_q[k].cyc - acc_cyc_q[k*PE + PE - 1]) !== 2) begin
          fails++;
          $display("FAIL simul_latency set=%0d got=%0d exp=2", k, sets_q[k].cyc - acc_cyc_q[k*PE + PE - 1]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int c, nsets, budget;
      c = (f == 0) ? 127 : int'($urandom_range(1, 127));
      nsets = (c + PE - 1) / PE;
      clear_obs();
      pulse_frame_credit();
      start_frame(7'(c));
      budget = 0;
      while (sets_q.size() < nsets && budget < 3000) begin
        tick();
        bbox_in = rand_bbox();
        bbox_valid = 1'($urandom_range(0, 1));
        ready_new_set = ($urandom_range(0, 3) == 0);
        budget++;
      end
      bbox_valid = 1'b0; ready_new_set = 1'b0;
      repeat (3) tick();
      checks++;
      if (sets_q.size() !== nsets || acc_q.size() !== c) begin
        fails++;
        $display("FAIL rnd_count frame=%0d got sets=%0d acc=%0d exp sets=%0d acc=%0d",
                 f, sets_q.size(), acc_q.size(), nsets, c);
      end
      for (int k = 0; k < sets_q.size(); k++) begin
        logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
        ev = exp_set(k, c); em = exp_meta(k, c);
        gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
        checks++;
        if (sets_q[k].data !== ev || gm !== em) begin
          fails++; d = first_diff(sets_q[k].data, ev);
          $display("FAIL rnd_set frame=%0d set=%0d got meta=%h slot%0d=%h exp meta=%h slot=%h",
                   f, k, gm, d, sets_q[k].data[d*BVS +: BVS], em, ev[d*BVS +: BVS]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int budget;
    clear_obs();
    start_frame(7'd72);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    budget = 0;
    while (acc_q.size() < 10 && budget < 100) begin
      tick();
      bbox_in = rand_bbox();
      budget++;
    end
    bbox_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, bbox_ready, new_frame, new_set_from_dma, frame_sent} !== 5'b0 ||
        set_of_bboxes_from_dma !== '0 || set_valid_cnt !== 5'd0 || sets_q.size() !== 0) begin
      fails++;
      $display("FAIL midrst_clear got ctrl=%b cnt=%0d set_nonzero=%0b sets=%0d exp ctrl=00000 cnt=0 set_nonzero=0 sets=0",
               {busy, bbox_ready, new_frame, new_set_from_dma, frame_sent}, set_valid_cnt,
               set_of_bboxes_from_dma != '0, sets_q.size());
    end
    clear_obs();
    start_frame(7'd5);
    bbox_valid = 1'b1; bbox_in = rand_bbox();
    budget = 0;
    while (sets_q.size() < 1 && budget < 100) begin
      tick();
      bbox_in = rand_bbox();
      budget++;
    end
    bbox_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (sets_q.size() !== 1 || acc_q.size() !== 5) begin
      fails++;
      $display("FAIL midrst_issue got sets=%0d acc=%0d exp sets=1 acc=5", sets_q.size(), acc_q.size());
    end
    for (int k = 0; k < sets_q.size(); k++) begin
      logic [SETW-1:0] ev; logic [7:0] em, gm; int d;
      ev = exp_set(k, 5); em = exp_meta(k, 5);
      gm = {sets_q[k].cnt, sets_q[k].nf, sets_q[k].ns, sets_q[k].fs};
      checks++;
      if (sets_q[k].data !== ev || gm !== em) begin
        fails++; d = first_diff(sets_q[k].data, ev);
        $display("FAIL midrst_set set=%0d got meta=%h slot%0d=%h exp meta=%h slot=%h",
                 k, gm, d, sets_q[k].data[d*BVS +: BVS], em, ev[d*BVS +: BVS]);
      end
      if (acc_cyc_q.size() == 5) begin
        checks++;
        if ((sets_q[k].cyc - acc_cyc_q[4]) !== 2) begin
          fails++;
          $display("FAIL midrst_latency got=%0d exp=2", sets_q[k].cyc - acc_cyc_q[4]);
        end
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    frame_start      = 1'b0;
    frame_bbox_count = '0;
    bbox_in          = '0;
    bbox_valid       = 1'b0;
    ready_new_frame  = 1'b0;
    ready_new_set    = 1'b0;
    test_reset();
    test_frame72();
    test_frame30();
    test_stall();
    test_ignore_start();
    test_simul_edge();
    test_random_frames();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/oflow_dma_set_packer.md
OFLOW_DMA_SET_PACKER -- requirements
Module: oflow_dma_set_packer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- PE_NUM, 24, bboxes per set / slots per output set.
- BBOX_VECTOR_SIZE, 86, bbox word width as {x,y,width,height,color1,color2}.
- FRAME_CNT_WIDTH, 7, width of per-frame bbox count (max 127).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- frame_start, in, 1, pulse: begin a new frame.
- frame_bbox_count, in, FRAME_CNT_WIDTH, bboxes in the frame; sampled with frame_start.
- bbox_in, in, BBOX_VECTOR_SIZE, streamed bbox word.
- bbox_valid, in, 1, bbox_in valid.
- bbox_ready, out, 1, packer accepts bbox_in this cycle.
- ready_new_frame, in, 1, from core; rising edge grants a frame credit.
- ready_new_set, in, 1, from core; rising edge grants a set credit.
- set_of_bboxes_from_dma, out, PE_NUM x BBOX_VECTOR_SIZE, registered set presented to core.
- set_valid_cnt, out, 5, valid slots in presented set (1..PE_NUM).
- new_frame, out, 1, one-cycle pulse: first set of frame presented.
- new_set_from_dma, out, 1, one-cycle pulse: non-first set presented.
- frame_sent, out, 1, one-cycle pulse: last set of frame presented.
- busy, out, 1, high in every state except IDLE.

Function
REQ-003 FSM SHALL have states IDLE, FILL, WAIT_CREDIT; any other encoding SHALL return to IDLE.
REQ-004 IDLE: frame_start with frame_bbox_count>0 SHALL latch the count, clear the bbox counter and slot index, clear first_set_sent, and go to FILL; a count of 0 SHALL be ignored.
REQ-005 frame_start outside IDLE SHALL be ignored with no state change.
REQ-006 bbox_ready SHALL be high only in FILL; a handshake is bbox_valid and bbox_ready in the same cycle.
REQ-007 Each handshake SHALL write bbox_in to fill slot [slot index], then increment the slot index and the frame bbox counter.
REQ-008 The set SHALL be complete on the handshake that fills slot PE_NUM-1, or on the handshake that makes the frame bbox counter equal the latched count; FSM then goes to WAIT_CREDIT.
REQ-009 On set completion, unfilled slots in the fill buffer SHALL read as zero, and the valid count SHALL equal the slots written.
REQ-010 frame_credit SHALL be set by a ready_new_frame rising edge, detected against a 1-cycle registered copy; set_credit SHALL be set likewise by a ready_new_set rising edge.
REQ-011 Credit update SHALL be credit_next = edge | (credit & ~consume), so a simultaneous edge and consume leaves the credit at 1.
REQ-012 WAIT_CREDIT SHALL require frame_credit when first_set_sent=0, and set_credit otherwise.
REQ-013 When the required credit is 1, the issue cycle SHALL:
- copy the fill buffer to set_of_bboxes_from_dma;
- load set_valid_cnt;
- consume the credit;
- assert new_frame (first set) or new_set_from_dma (other sets) on the next cycle, aligned with the updated outputs.
REQ-014 In the issue cycle, the fill buffer and slot index SHALL clear; if bboxes remain, FSM SHALL go to FILL, else it SHALL pulse frame_sent together with the new_* pulse and go to IDLE.
REQ-015 Latency: set completion in cycle N with credit already present SHALL give the issue in cycle N+1, the pulse and outputs valid in cycle N+2, and bbox_ready high again in cycle N+2.
REQ-016 set_of_bboxes_from_dma and set_valid_cnt SHALL hold stable between issues.
REQ-017 Credits SHALL persist across frames and SHALL change only per REQ-011.

Reset
REQ-018 reset SHALL asynchronously force:
- FSM to IDLE;
- all outputs, the fill buffer, counters and edge registers to 0;
- frame_credit to 1 (core idle after reset) and set_credit to 0.
REQ-019 Reset mid-frame SHALL discard the partial set, with no pulses emitted.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- count=72, continuous bbox_valid, ready_new_set edge after each set -> new_frame, then 2 new_set_from_dma, each set_valid_cnt=24; frame_sent with 3rd pulse.
- count=30 -> set 0 set_valid_cnt=24; set 1 set_valid_cnt=6, slots 6..23 = 0, frame_sent asserted.
- count=72, no ready_new_set edge after set 0 -> bbox_ready low after 48th accept; outputs hold set 0; an edge resumes flow.
- frame_start during FILL, and frame_start with count=0 in IDLE -> no state change, busy unchanged.
- reset asserted after 10 bboxes -> busy=0, outputs 0; next frame's first set issues without a ready_new_frame edge.
- ready_new_set rising edge in the same cycle set_credit is consumed -> the next completed set issues without a further edge.
